dds_tune_ctrl: RTL and testbench

//   Downstream of key_ctrl. Converts the debounced frequency index and waveform select

---
 rtl/dds_tune_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dds_tune_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_tune_ctrl.sv
// -----------------------------------------------------------------------------
// dds_tune_ctrl
//
// Purpose
//   Turns a frequency index and a waveform select into a DDS frequency tuning
//   word, runs the phase accumulator, and forms the waveform-ROM address.
//   The tuning word is FTW_MIN + idx * FTW_STEP. It is built by a serial
//   shift-add multiply, one index bit per cycle, LSB first.
//   A new tuning word and waveform are committed only on a phase wrap. A switch
//   therefore never breaks the output waveform in the middle of a period.
//
// Ports
//   sys_clk    in   1           clock, all logic on the rising edge
//   sys_rst    in   1           synchronous reset, active-high
//   freq_idx   in   IDX_W       requested frequency index
//   wave_sel   in   2           requested waveform
//   ftw_out    out  ACC_W       tuning word currently driving the accumulator
//   rom_addr   out  ADDR_W+2    {active waveform, top ADDR_W accumulator bits}
//   busy       out  1           a new setting is being computed or is waiting
//                               for a wrap
//   upd_pulse  out  1           one-cycle pulse in the cycle after a new
//                               setting takes effect
// -----------------------------------------------------------------------------
module dds_tune_ctrl #(
    parameter int unsigned     ACC_W    = 32,
    parameter int unsigned     ADDR_W   = 12,
    parameter int unsigned     IDX_W    = 5,
    parameter longint unsigned FTW_MIN  = 42950,
    parameter longint unsigned FTW_STEP = 4155035,
    parameter int unsigned     MAX_IDX  = 31
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [IDX_W-1:0]    freq_idx,
    input  logic [1:0]          wave_sel,
    output logic [ACC_W-1:0]    ftw_out,
    output logic [ADDR_W+1:0]   rom_addr,
    output logic                busy,
    output logic                upd_pulse
);

    localparam logic [ACC_W-1:0] FTW_MIN_C  = ACC_W'(FTW_MIN);
    localparam logic [ACC_W-1:0] FTW_STEP_C = ACC_W'(FTW_STEP);

    // An index field too narrow to reach MAX_IDX never needs clamping.
    localparam logic [IDX_W-1:0] MAX_IDX_C =
        (longint'(MAX_IDX) >= (longint'(1) << IDX_W)) ? {IDX_W{1'b1}} : IDX_W'(MAX_IDX);

    localparam int unsigned      CNT_W    = (IDX_W > 1) ? $clog2(IDX_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IDX_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] idx_q,         idx_d;
    logic [1:0]       wave_q,        wave_d;
    logic [ACC_W-1:0] acc_q,         acc_d;
    logic [ACC_W-1:0] ftw_q,         ftw_d;
    logic [ACC_W-1:0] ftw_pend_q,    ftw_pend_d;
    logic [ACC_W-1:0] product_q,     product_d;
    logic [IDX_W-1:0] req_idx_q,     req_idx_d;
    logic [1:0]       req_wave_q,    req_wave_d;
    logic [1:0]       wave_active_q, wave_active_d;
    logic [CNT_W-1:0] bit_cnt_q,     bit_cnt_d;
    logic [1:0]       state_q,       state_d;
    logic             upd_q,         upd_d;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic             wrap;
    logic [IDX_W-1:0] idx_clamped;
    logic             req_mismatch;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] product_sum;

    // FTW_STEP pre-shifted by every bit weight of the index.
    logic [ACC_W-1:0] step_shl [IDX_W];

    genvar gi;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_step_shl
            assign step_shl[gi] = FTW_STEP_C << gi;
        end
    endgenerate

    // The carry out of the accumulator add marks the phase wrap.
    assign {wrap, acc_d} = {1'b0, acc_q} + {1'b0, ftw_q};

    assign idx_d  = freq_idx;
    assign wave_d = wave_sel;

    // The compare uses the clamped index. Otherwise an out-of-range index would
    // never equal the latched request, and the FSM would recompute forever.
    assign idx_clamped  = (idx_q > MAX_IDX_C) ? MAX_IDX_C : idx_q;
    assign req_mismatch = ({idx_clamped, wave_q} != {req_idx_q, req_wave_q});

    assign addend      = req_idx_q[bit_cnt_q] ? step_shl[bit_cnt_q] : '0;
    assign product_sum = product_q + addend;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        req_idx_d     = req_idx_q;
        req_wave_d    = req_wave_q;
        product_d     = product_q;
        bit_cnt_d     = bit_cnt_q;
        ftw_pend_d    = ftw_pend_q;
        ftw_d         = ftw_q;
        wave_active_d = wave_active_q;
        upd_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_mismatch) begin
                    req_idx_d  = idx_clamped;
                    req_wave_d = wave_q;
                    product_d  = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_MUL;
                end
            end

            ST_MUL: begin
                // Inputs are deliberately ignored here. The IDLE/WAIT compare
                // picks up any change afterwards.
                product_d = product_sum;
                if (bit_cnt_q == LAST_BIT) begin
                    ftw_pend_d = FTW_MIN_C + product_sum;
                    state_d    = ST_WAIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT: begin
                // A newer request takes priority over committing a stale one.
                if (req_mismatch) begin
                    req_idx_d  = idx_clamped;
                    req_wave_d = wave_q;
                    product_d  = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_MUL;
                end else if (wrap) begin
                    // The accumulator add on this edge still uses the old FTW.
                    ftw_d         = ftw_pend_q;
                    wave_active_d = req_wave_q;
                    upd_d         = 1'b1;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idx_q         <= '0;
            wave_q        <= '0;
            acc_q         <= '0;
            ftw_q         <= FTW_MIN_C;
            ftw_pend_q    <= '0;
            product_q     <= '0;
            req_idx_q     <= '0;
            req_wave_q    <= '0;
            wave_active_q <= '0;
            bit_cnt_q     <= '0;
            state_q       <= ST_IDLE;
            upd_q         <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            wave_q        <= wave_d;
            acc_q         <= acc_d;
            ftw_q         <= ftw_d;
            ftw_pend_q    <= ftw_pend_d;
            product_q     <= product_d;
            req_idx_q     <= req_idx_d;
            req_wave_q    <= req_wave_d;
            wave_active_q <= wave_active_d;
            bit_cnt_q     <= bit_cnt_d;
            state_q       <= state_d;
            upd_q         <= upd_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ftw_out   = ftw_q;
    assign rom_addr  = {wave_active_q, acc_q[ACC_W-1 -: ADDR_W]};
    assign busy      = (state_q == ST_MUL) || (state_q == ST_WAIT);
    assign upd_pulse = upd_q;

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_tune_ctrl
//
// Directed test of dds_tune_ctrl. The accumulator is 28 bits wide, so a wrap at
// the minimum tuning word takes about 6.2k cycles. All tuning words used here
// (<= 128849035) fit in 28 bits, so the hand-computed FTW values are the same
// as for the 32-bit default.
// A second instance with MAX_IDX=20 is driven with freq_idx=31 to cover
// clamping.
// -----------------------------------------------------------------------------
module tb_dds_tune_ctrl;

    localparam logic [27:0] FTW_MIN = 28'd42950;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  freq;
    logic [1:0]  wave;
    logic [27:0] ftw;
    logic [13:0] rom;
    logic        busy;
    logic        upd;

    logic        rst_b;
    logic [4:0]  freq_b;
    logic [1:0]  wave_b;
    logic [27:0] ftw_b;
    logic [13:0] rom_b;
    logic        busy_b;
    logic        upd_b;

    dds_tune_ctrl #(.ACC_W(28)) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .freq_idx  (freq),
        .wave_sel  (wave),
        .ftw_out   (ftw),
        .rom_addr  (rom),
        .busy      (busy),
        .upd_pulse (upd)
    );

    dds_tune_ctrl #(.ACC_W(28), .MAX_IDX(20)) dut_b (
        .sys_clk   (clk),
        .sys_rst   (rst_b),
        .freq_idx  (freq_b),
        .wave_sel  (wave_b),
        .ftw_out   (ftw_b),
        .rom_addr  (rom_b),
        .busy      (busy_b),
        .upd_pulse (upd_b)
    );

    int          total = 0;
    int          bad   = 0;

    // Reference state of the main instance.
    logic [27:0] acc_m;
    logic [27:0] ftw_m;
    logic [1:0]  wave_m;
    logic        wrap_m;
    int          ecnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference accumulator, then return at the negedge.
    task automatic step();
        logic [28:0] s;
        @(posedge clk);
        s      = {1'b0, acc_m} + {1'b0, ftw_m};
        wrap_m = s[28];
        acc_m  = s[27:0];
        ecnt++;
        @(negedge clk);
    endtask

    // Idle cycles: no activity. The ROM address follows the reference.
    task automatic quiet(input string tag, input int n);
        int viol;
        viol = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (busy !== 1'b0 || upd !== 1'b0 || ftw !== ftw_m ||
                rom !== {wave_m, acc_m[27:16]})
                viol++;
        end
        chk(tag, 64'(viol), 64'd0);
    endtask

    // Wait for the first wrap at or after edge min_e (counted from the input
    // change). Until then, the old FTW and waveform must hold and the
    // accumulator must keep tracking. On that edge, the new values must appear
    // together with upd_pulse.
    task automatic wait_apply(input string tag, input logic [27:0] new_ftw,
                              input logic [1:0] new_wave, input int min_e);
        logic [27:0] old_ftw;
        logic [1:0]  old_wave;
        int          viol;
        bit          done;
        old_ftw  = ftw_m;
        old_wave = wave_m;
        viol     = 0;
        done     = 1'b0;
        for (int i = 0; i < 10000 && !done; i++) begin
            step();
            if (wrap_m && ecnt >= min_e) begin
                done   = 1'b1;
                ftw_m  = new_ftw;
                wave_m = new_wave;
            end else if (ftw !== old_ftw || upd !== 1'b0 ||
                         rom !== {old_wave, acc_m[27:16]}) begin
                viol++;
            end
        end
        chk({tag, "_applied"}, 64'(done), 64'd1);
        chk({tag, "_hold"},    64'(viol), 64'd0);
        chk({tag, "_ftw"},     64'(ftw),  64'(new_ftw));
        chk({tag, "_upd"},     64'(upd),  64'd1);
        chk({tag, "_busy"},    64'(busy), 64'd0);
        chk({tag, "_rom"},     64'(rom),  64'({new_wave, acc_m[27:16]}));
        $display("%s: ftw_out=%0d wave=%0d at edge %0d", tag, ftw, rom[13:12], ecnt);
        step();
        chk({tag, "_upd_clr"}, 64'(upd),  64'd0);
    endtask

    initial begin
        rst    = 1'b1;
        freq   = 5'd0;
        wave   = 2'd0;
        rst_b  = 1'b1;
        freq_b = 5'd31;
        wave_b = 2'd0;
        acc_m  = '0;
        ftw_m  = FTW_MIN;
        wave_m = 2'd0;
        wrap_m = 1'b0;
        ecnt   = 0;

        // ---- 1: reset state and idle accumulation ---------------------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ftw",  64'(ftw),  64'(FTW_MIN));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_upd",  64'(upd),  64'd0);
        chk("rst_rom",  64'(rom),  64'd0);
        rst   = 1'b0;
        rst_b = 1'b0;
        quiet("t1_idle", 20);
        $display("t1: idle after reset, rom_addr=%0h", rom);

        // ---- 2: freq_idx 0 -> 31 --------------------------------------------
        freq = 5'd31;
        ecnt = 0;
        step();
        chk("t2_busy_e1", 64'(busy), 64'd0);
        step();
        chk("t2_busy_e2", 64'(busy), 64'd1);
        wait_apply("t2_idx31", 28'd128849035, 2'd0, 8);

        // ---- 3: wave-only change, FTW unchanged -----------------------------
        wave = 2'd2;
        ecnt = 0;
        wait_apply("t3_wave2", 28'd128849035, 2'd2, 8);

        // ---- 4: index 3 then 5 while waiting for the wrap -------------------
        // Choose a phase with no wrap on edge 8, so that idx 3 cannot be
        // committed before the change to 5 is seen.
        for (int i = 0; i < 8; i++) begin
            logic [28:0] a;
            a = {1'b0, acc_m};
            for (int k = 0; k < 7; k++) a = {1'b0, a[27:0] + ftw_m};
            a = {1'b0, a[27:0]} + {1'b0, ftw_m};
            if (!a[28]) break;
            step();
        end
        freq = 5'd3;
        ecnt = 0;
        repeat (7) step();
        chk("t4_busy_wait", 64'(busy), 64'd1);
        freq = 5'd5;
        wait_apply("t4_idx5", 28'd20818125, 2'd2, 15);

        // ---- 5: index 2 -> 7 during the multiply -----------------------------
        freq = 5'd2;
        ecnt = 0;
        repeat (3) step();
        chk("t5_busy_mul", 64'(busy), 64'd1);
        freq = 5'd7;
        wait_apply("t5_idx7", 28'd29128195, 2'd2, 14);

        // ---- 6: reset during the wrap wait -----------------------------------
        freq = 5'd9;
        ecnt = 0;
        repeat (7) step();
        chk("t6_busy_pre", 64'(busy), 64'd1);
        rst  = 1'b1;
        freq = 5'd0;
        wave = 2'd0;
        step();
        acc_m  = '0;
        ftw_m  = FTW_MIN;
        wave_m = 2'd0;
        chk("t6_rst_ftw",  64'(ftw),  64'(FTW_MIN));
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_upd",  64'(upd),  64'd0);
        chk("t6_rst_rom",  64'(rom),  64'd0);
        rst = 1'b0;
        quiet("t6_after_rst", 12);
        $display("t6: reset in wait, ftw_out=%0d", ftw);

        // ---- clamp: MAX_IDX=20 instance, freq_idx=31 ------------------------
        for (int i = 0; i < 8000 && ftw_b !== 28'd83143650; i++) step();
        chk("clamp_ftw", 64'(ftw_b), 64'd83143650);
        repeat (3) step();
        chk("clamp_busy",    64'(busy_b), 64'd0);
        chk("clamp_upd",     64'(upd_b),  64'd0);
        chk("clamp_wave",    64'(rom_b[13:12]), 64'd0);
        chk("clamp_rom_def", 64'((^rom_b) === 1'bx), 64'd0);
        $display("clamp: ftw_out=%0d", ftw_b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
